// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined RV32I core.
// Owns the program counter, presents it combinationally to the instruction
// ROM and registers the returned word, its PC and PC+4 into IF/ID.
// Optional build macro: FETCH_MISALIGN_TRAP_EN. When defined, redirects to a
// target that is not word aligned are steered to TRAP_PC and reported on
// misaligned/bad_target. When undefined, targets are loaded verbatim.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'hBFC0_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_PC     = 32'hBFC0_0FF0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  input  logic [INSTR_WIDTH-1:0] instr_f,
  output logic [ADDR_WIDTH-1:0]  pc_f,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_d,
  output logic                   valid_d,
  output logic                   misaligned,
  output logic [ADDR_WIDTH-1:0]  bad_target
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_plus4_f;
  logic [ADDR_WIDTH-1:0] next_redirect_pc;
  logic                  target_misaligned;

  // Sequential PC; modulo wrap at the top of the address space is intended.
  assign pc_plus4_f = pc_f + PC_STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A redirect whose low two bits are nonzero goes to the trap vector instead.
  assign target_misaligned = (redirect_target[1:0] != 2'b00);
  assign next_redirect_pc  = target_misaligned ? TRAP_PC : redirect_target;

  // misaligned is a single-cycle pulse; bad_target remembers the last offender.
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned <= 1'b0;
      bad_target <= '0;
    end else if (redirect && target_misaligned) begin
      misaligned <= 1'b1;
      bad_target <= redirect_target;
    end else begin
      misaligned <= 1'b0;
    end
  end
`else
  logic unused_trap_pc;

  // Without the alignment check the target is taken as-is and the trap
  // reporting outputs stay quiet.
  assign target_misaligned = 1'b0;
  assign next_redirect_pc  = redirect_target;
  assign misaligned        = 1'b0;
  assign bad_target        = '0;
  assign unused_trap_pc    = ^{TRAP_PC, target_misaligned};
`endif

  // PC and IF/ID update with priority reset > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f       <= RESET_PC;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (redirect) begin
      pc_f       <= next_redirect_pc;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall) begin
      pc_f       <= pc_plus4_f;
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Each observation packs {pc_f, instr_d, pc_d, pc_plus4_d, valid_d,
// misaligned, bad_target} and compares it against a hand-computed vector.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misaligned;
  logic [31:0] bad_target;

  int errors = 0;
  int checks = 0;

  logic [161:0] observed;
  logic [161:0] expected;

  assign observed = {pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misaligned, bad_target};

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_f         (instr_f),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .misaligned      (misaligned),
    .bad_target      (bad_target)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, take one edge, and settle 1 ns past it.
  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] tgt, input logic [31:0] ins);
    rst             = r;
    stall           = s;
    redirect        = rd;
    redirect_target = tgt;
    instr_f         = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
    expected = {32'hBFC0_0000, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
    expected = {32'hBFC0_0004, 32'h0050_0093, 32'hBFC0_0000, 32'hBFC0_0004, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL reset_release_first_fetch: got %h want %h", observed, expected);
    end
  endtask

  task automatic test_stall();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0010_0113);
    expected = {32'hBFC0_0008, 32'h0010_0113, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL second_fetch: got %h want %h", observed, expected);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF + i);
      checks++;
      if (observed !== expected) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got %h want %h", i, observed, expected);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0020_0193);
    expected = {32'hBFC0_000C, 32'h0020_0193, 32'hBFC0_0008, 32'hBFC0_000C, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL stall_release: got %h want %h", observed, expected);
    end
  endtask

  task automatic test_redirect_during_stall();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hBFC0_0100, 32'hCAFE_F00D);
    expected = {32'hBFC0_0100, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL redirect_over_stall: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0030_0213);
    expected = {32'hBFC0_0104, 32'h0030_0213, 32'hBFC0_0100, 32'hBFC0_0104, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL redirect_then_advance: got %h want %h", observed, expected);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0300, 32'h1111_1111);
    expected = {32'hBFC0_0300, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0400, 32'h2222_2222);
    expected = {32'hBFC0_0400, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0293);
    expected = {32'hBFC0_0404, 32'h0040_0293, 32'hBFC0_0400, 32'hBFC0_0404, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL b2b_advance: got %h want %h", observed, expected);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0313);
    expected = {32'h0000_0000, 32'h0050_0313, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL wrap_top: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0060_0393);
    expected = {32'h0000_0004, 32'h0060_0393, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL wrap_after: got %h want %h", observed, expected);
    end
  endtask

  task automatic test_redirect_after_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0500, 32'h0050_0093);
    expected = {32'hBFC0_0500, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL first_cycle_redirect: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0070_0413);
    expected = {32'hBFC0_0504, 32'h0070_0413, 32'hBFC0_0500, 32'hBFC0_0504, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL first_cycle_redirect_advance: got %h want %h", observed, expected);
    end
  endtask

  task automatic test_misalign();
`ifdef FETCH_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 32'h0);
    expected = {32'hBFC0_0FF0, NOP, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBFC0_0102};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL misalign_trap: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0104, 32'h0);
    expected = {32'hBFC0_0104, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'hBFC0_0102};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL aligned_after_trap: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0080_0493);
    expected = {32'hBFC0_0108, 32'h0080_0493, 32'hBFC0_0104, 32'hBFC0_0108, 1'b1, 1'b0, 32'hBFC0_0102};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL bad_target_hold: got %h want %h", observed, expected);
    end
`else
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 32'h0);
    expected = {32'hBFC0_0102, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL verbatim_target: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0080_0493);
    expected = {32'hBFC0_0106, 32'h0080_0493, 32'hBFC0_0102, 32'hBFC0_0106, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL verbatim_advance: got %h want %h", observed, expected);
    end
`endif
  endtask

  task automatic test_reset_mid_redirect();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hBFC0_0200, 32'h0090_0513);
    expected = {32'hBFC0_0000, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL reset_beats_redirect: got %h want %h", observed, expected);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h00A0_0593);
    expected = {32'hBFC0_0004, 32'h00A0_0593, 32'hBFC0_0000, 32'hBFC0_0004, 1'b1, 1'b0, 32'h0};
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL reset_release_again: got %h want %h", observed, expected);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    instr_f         = 32'h0;
    test_reset();
    test_stall();
    test_redirect_during_stall();
    test_back_to_back();
    test_wrap();
    test_redirect_after_reset();
    test_misalign();
    test_reset_mid_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
